// File: rtl/line_feeder.sv
// Frame line buffer: accepts DEPTH lines from a loader, then feeds them one at a
// time to a downstream controller, advancing on each readLine pulse.
module line_feeder #(
  parameter int W     = 25,
  parameter int DEPTH = 64,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [W-1:0]  load_data,
  output logic          load_ready,
  output logic          start,
  input  logic          readLine,
  output logic [W-1:0]  line,
  output logic [CW-1:0] count,
  output logic          line_valid,
  output logic          frame_done,
  output logic [1:0]    state_dbg
);

  // Handshake: a load beat transfers on any cycle where load_valid and
  // load_ready are both high; load_ready depends only on the FSM state, never
  // on load_valid. readLine is a one-cycle pulse honoured only while feeding.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   mem [DEPTH];
  logic [CW-1:0]  wr_ptr;
  logic           accept;
  logic           last_beat;
  logic           advance;
  logic           last_line;

  assign state_dbg = state;

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    start      = 1'b0;
    line_valid = 1'b0;
    frame_done = 1'b0;
    accept     = 1'b0;
    last_beat  = 1'b0;
    advance    = 1'b0;
    last_line  = 1'b0;
    case (state)
      IDLE, LOAD: begin
        load_ready = 1'b1;
        accept     = load_valid;
        last_beat  = load_valid && (wr_ptr == CW'(DEPTH - 1));
        if (load_valid) begin
          state_next = last_beat ? FEED : LOAD;
        end
      end
      FEED: begin
        start      = 1'b1;
        line_valid = 1'b1;
        advance    = readLine;
        last_line  = readLine && (count == CW'(DEPTH - 1));
        if (last_line) begin
          state_next = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Line storage is not cleared on reset; wr_ptr restarting at 0 guarantees a
  // stale frame can never reach FEED.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      line   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= last_beat ? '0 : wr_ptr + CW'(1);
      end
      if (last_beat) begin
        count <= '0;
        // With a single-line frame the first line is still being written.
        line  <= (wr_ptr == '0) ? load_data : mem[0];
      end else if (advance) begin
        if (last_line) begin
          count <= '0;
        end else begin
          count <= count + CW'(1);
          line  <= mem[count + CW'(1)];
        end
      end
    end
  end

endmodule

// File: tb/tb_line_feeder.sv
// Bench for line_feeder: a frame-level queue model predicts every output each
// cycle, with literal expectations pinning the key frame boundaries.
module tb_line_feeder;

  localparam int W     = 25;
  localparam int DEPTH = 64;
  localparam int CW    = 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          load_valid;
  logic [W-1:0]  load_data;
  logic          load_ready;
  logic          start;
  logic          readLine;
  logic [W-1:0]  line;
  logic [CW-1:0] count;
  logic          line_valid;
  logic          frame_done;
  logic [1:0]    state_dbg;

  line_feeder #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .readLine   (readLine),
    .line       (line),
    .count      (count),
    .line_valid (line_valid),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / model: exp_q holds the frame being loaded or fed
  logic [W-1:0] exp_q[$];
  bit           m_feeding;
  bit           m_done;
  int           m_idx;
  logic [W-1:0] m_line;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_feeding = 1'b0;
      m_done    = 1'b0;
      m_idx     = 0;
      m_line    = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_feeding) begin
      if (readLine) begin
        if (m_idx == DEPTH - 1) begin
          m_feeding = 1'b0;
          m_done    = 1'b1;
          m_idx     = 0;
          exp_q.delete();
        end else begin
          m_idx  = m_idx + 1;
          m_line = exp_q[m_idx];
        end
      end
    end else if (load_valid) begin
      exp_q.push_back(load_data);
      if (exp_q.size() == DEPTH) begin
        m_feeding = 1'b1;
        m_idx     = 0;
        m_line    = exp_q[0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("load_ready", 32'(load_ready), 32'(!(m_feeding || m_done)));
      chk("start",      32'(start),      32'(m_feeding));
      chk("line_valid", 32'(line_valid), 32'(m_feeding));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("count",      32'(count),      32'(m_idx));
      chk("line",       32'(line),       32'(m_line));
    end
  end

  // driver tasks
  function automatic logic [W-1:0] pat(input int mode, input int i);
    case (mode)
      0:       return W'(i * 3 + 1);
      2:       return W'(i) ^ 25'h0AAAAAA;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic load_frame(input int mode, input int duty, input int beats);
    int i = 0;
    int guard = 0;
    while (i < beats && guard < 5000) begin
      @(negedge clk);
      guard++;
      rst      = 1'b0;
      readLine = 1'($urandom_range(1));
      if ($urandom_range(99) < duty) begin
        load_valid = 1'b1;
        load_data  = pat(mode, i);
        i++;
      end else begin
        load_valid = 1'b0;
        load_data  = W'($urandom);
      end
    end
    if (i < beats) chk("load_frame_budget", 32'(i), 32'(beats));
  endtask

  task automatic feed_random(input int pulses, input int lv_pct);
    int p = 0;
    int guard = 0;
    while (p < pulses && guard < 5000) begin
      @(negedge clk);
      guard++;
      readLine   = 1'($urandom_range(1));
      load_valid = ($urandom_range(99) < lv_pct);
      load_data  = 25'h1FFFFFF;
      if (readLine) p++;
    end
    if (p < pulses) chk("feed_budget", 32'(p), 32'(pulses));
  endtask

  task automatic idle_inputs();
    readLine   = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  initial begin
    int fd;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_state_dbg", 32'(state_dbg), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_line", 32'(line), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    rst = 1'b0;

    // contiguous load of i*3+1, then readLine every 4th cycle with load junk
    load_frame(0, 100, DEPTH);
    @(negedge clk);
    idle_inputs();
    chk("feed0_load_ready", 32'(load_ready), 32'd0);
    chk("feed0_start", 32'(start), 32'd1);
    chk("feed0_count", 32'(count), 32'd0);
    chk("feed0_line", 32'(line), 32'd1);
    for (int p = 0; p < DEPTH; p++) begin
      @(negedge clk);
      readLine   = 1'b1;
      load_valid = 1'b1;
      load_data  = 25'h1FFFFFF;
      @(negedge clk);
      readLine   = 1'b0;
      load_valid = (p < DEPTH - 1);
      if (p < DEPTH - 1) begin
        chk("step_count", 32'(count), 32'(p + 1));
        chk("step_line", 32'(line), 32'((p + 1) * 3 + 1));
      end else begin
        chk("end_frame_done", 32'(frame_done), 32'd1);
        chk("end_line_valid", 32'(line_valid), 32'd0);
      end
      if (p < DEPTH - 1) begin
        repeat (2) @(negedge clk);
      end
    end
    @(negedge clk);
    chk("after_done_load_ready", 32'(load_ready), 32'd1);
    chk("after_done_frame_done", 32'(frame_done), 32'd0);
    idle_inputs();

    // gappy random load, random readLine with loader junk in FEED
    load_frame(1, 50, DEPTH);
    feed_random(DEPTH, 50);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    // reset at count 20 in FEED
    load_frame(1, 70, DEPTH);
    @(negedge clk);
    idle_inputs();
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      readLine = 1'b1;
    end
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd20);
    rst        = 1'b1;
    readLine   = 1'b1;
    load_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    chk("midfeed_rst_count", 32'(count), 32'd0);
    chk("midfeed_rst_line", 32'(line), 32'd0);
    chk("midfeed_rst_start", 32'(start), 32'd0);
    chk("midfeed_rst_line_valid", 32'(line_valid), 32'd0);
    chk("midfeed_rst_load_ready", 32'(load_ready), 32'd1);

    // new xor pattern, readLine held high ~70 cycles
    load_frame(2, 100, DEPTH);
    @(negedge clk);
    idle_inputs();
    chk("xor_first_line", 32'(line), 32'h0AAAAAA);
    readLine = 1'b1;
    fd = 0;
    repeat (69) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    readLine = 1'b0;
    chk("held_frame_done_pulses", 32'(fd), 32'd1);
    @(negedge clk);

    // reset mid-LOAD, then a full frame, then reset on the last readLine
    load_frame(1, 100, 30);
    @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    load_frame(1, 60, DEPTH);
    @(negedge clk);
    idle_inputs();
    for (int p = 0; p < DEPTH - 1; p++) begin
      @(negedge clk);
      readLine = 1'b1;
    end
    @(negedge clk);
    chk("pre_last_count", 32'(count), 32'(DEPTH - 1));
    rst      = 1'b1;
    readLine = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    chk("suppressed_frame_done", 32'(frame_done), 32'd0);
    chk("suppressed_load_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    chk("suppressed_frame_done_next", 32'(frame_done), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
